// File: rtl/ifid_skidreg.sv
// IF/ID two-entry skid register: valid/ready on both sides, registered in_ready,
// NOP (all-zero instruction) presented when empty. Define IFID_PERF_EN for the decode-stall counter.
module ifid_skidreg #(
    parameter int INSWIDTH = 32,
    parameter int AWIDTH   = 32,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSWIDTH-1:0] insin,
    input  logic [AWIDTH-1:0]   pcnextin,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [INSWIDTH-1:0] insout,
    output logic [AWIDTH-1:0]   pcnextout,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                flush,
    output logic [CNTWIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BAD   = 2'b01,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_t;

    logic [INSWIDTH-1:0] ins_m_q, ins_m_d, ins_s_q, ins_s_d;
    logic [AWIDTH-1:0]   pc_m_q, pc_m_d, pc_s_q, pc_s_d;
    logic                v_m_q, v_m_d, v_s_q, v_s_d;
    logic                in_fire, out_fire;
    state_t              state;

    // The state is just the two valid bits viewed as an enum.
    assign state     = state_t'({v_m_q, v_s_q});
    assign in_ready  = ~v_s_q;
    assign out_valid = v_m_q;
    assign insout    = v_m_q ? ins_m_q : '0;
    assign pcnextout = pc_m_q;
    assign in_fire   = in_valid & ~v_s_q;
    assign out_fire  = v_m_q & out_ready;

    always_comb begin
        ins_m_d = ins_m_q;
        pc_m_d  = pc_m_q;
        v_m_d   = v_m_q;
        ins_s_d = ins_s_q;
        pc_s_d  = pc_s_q;
        v_s_d   = v_s_q;
        if (flush) begin
            // Squash wins over any same-cycle handshake; PCs are left as-is.
            v_m_d   = 1'b0;
            v_s_d   = 1'b0;
            ins_m_d = '0;
            ins_s_d = '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        ins_m_d = insin;
                        pc_m_d  = pcnextin;
                        v_m_d   = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        ins_m_d = insin;
                        pc_m_d  = pcnextin;
                    end else if (in_fire) begin
                        ins_s_d = insin;
                        pc_s_d  = pcnextin;
                        v_s_d   = 1'b1;
                    end else if (out_fire) begin
                        v_m_d = 1'b0;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        ins_m_d = ins_s_q;
                        pc_m_d  = pc_s_q;
                        v_s_d   = 1'b0;
                    end
                end
                default: begin
                    v_m_d = 1'b0;
                    v_s_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_m_q <= '0;
            pc_m_q  <= '0;
            v_m_q   <= 1'b0;
            ins_s_q <= '0;
            pc_s_q  <= '0;
            v_s_q   <= 1'b0;
        end else begin
            ins_m_q <= ins_m_d;
            pc_m_q  <= pc_m_d;
            v_m_q   <= v_m_d;
            ins_s_q <= ins_s_d;
            pc_s_q  <= pc_s_d;
            v_s_q   <= v_s_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [CNTWIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Counts decode stalls regardless of flush; saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (v_m_q && !out_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
